// File: rtl/number_display_seq.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS active-low seven-segment digits.
// Optional blink support is enabled with the NUMBER_DISPLAY_BLINK_EN macro.
module number_display_seq #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_WIDTH-1:0]  binary,
    input  logic                  load,
    input  logic                  blank_lz,
`ifdef NUMBER_DISPLAY_BLINK_EN
    input  logic                  blink,
`endif
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  valid,
    output logic                  overflow
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    // Handshake: load is a single-cycle request, accepted whenever it is high;
    // while busy it lands in the pending slot, and valid pulses once per display update.
    state_t                 state, next_state;
    logic [BIN_WIDTH-1:0]   shift_q;
    logic [4*DIGITS-1:0]    bcd_q;
    logic [4*DIGITS-1:0]    bcd_adj;
    logic [CW-1:0]          cnt_q;
    logic                   ovf_pend;
    logic                   pend_valid;
    logic [BIN_WIDTH-1:0]   pend_val;
    logic [7*DIGITS-1:0]    disp_q;
    logic [7*DIGITS-1:0]    seg_next;
    logic                   load_now;
    logic [BIN_WIDTH-1:0]   load_val;
    logic                   seen_nz;
    logic [3:0]             nib;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_now   = 1'b0;
        load_val   = binary;
        case (state)
            IDLE: begin
                if (load) begin
                    load_now   = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(BIN_WIDTH - 1)) next_state = UPDATE;
            end
            UPDATE: begin
                // A load arriving with UPDATE is the newest pending value and wins.
                if (load || pend_valid) begin
                    load_now   = 1'b1;
                    load_val   = load ? binary : pend_val;
                    next_state = SHIFT;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end
    end

    // Scan from the most significant digit so blanking stops at the first nonzero one.
    always_comb begin
        seg_next = '1;
        seen_nz  = 1'b0;
        nib      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if (nib != 4'd0) seen_nz = 1'b1;
            if (ovf_pend)
                seg_next[7*i +: 7] = 7'h3F;
            else if (blank_lz && !seen_nz && i != 0)
                seg_next[7*i +: 7] = 7'h7F;
            else
                seg_next[7*i +: 7] = seg7(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend   <= 1'b0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            disp_q     <= '1;
            valid      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load_now) begin
                shift_q  <= load_val;
                bcd_q    <= '0;
                cnt_q    <= '0;
                ovf_pend <= (64'(load_val) > MAX_VAL);
            end else if (state == SHIFT) begin
                bcd_q   <= {bcd_adj[4*DIGITS-2:0], shift_q[BIN_WIDTH-1]};
                shift_q <= shift_q << 1;
                cnt_q   <= cnt_q + CW'(1);
            end

            if (state == UPDATE) begin
                disp_q     <= seg_next;
                overflow   <= ovf_pend;
                valid      <= 1'b1;
                pend_valid <= 1'b0;
            end else if (state == SHIFT && load) begin
                pend_valid <= 1'b1;
                pend_val   <= binary;
            end
        end
    end

`ifdef NUMBER_DISPLAY_BLINK_EN
    localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BCW-1:0] blink_cnt;
    logic           blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BCW'(1);
        end
    end

    assign hex = (blink && !blink_phase) ? '1 : disp_q;
`else
    assign hex = disp_q;
`endif

endmodule

// File: tb/tb_number_display_seq.sv
// Bench for number_display_seq: two instances (5 and 4 digits) against an arithmetic display model.
module tb_number_display_seq;

  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] binary = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;

  logic [34:0] hex5;
  logic [27:0] hex4;
  logic        busy5, valid5, ovf5;
  logic        busy4, valid4, ovf4;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  number_display_seq #(.BIN_WIDTH(BW), .DIGITS(5)) dut5 (
    .clk(clk), .reset(reset), .binary(binary), .load(load), .blank_lz(blank_lz),
`ifdef NUMBER_DISPLAY_BLINK_EN
    .blink(1'b0),
`endif
    .hex(hex5), .busy(busy5), .valid(valid5), .overflow(ovf5)
  );

  number_display_seq #(.BIN_WIDTH(BW), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .binary(binary), .load(load), .blank_lz(blank_lz),
`ifdef NUMBER_DISPLAY_BLINK_EN
    .blink(1'b0),
`endif
    .hex(hex4), .busy(busy4), .valid(valid4), .overflow(ovf4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: timeline of conversions plus arithmetic rendering
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic longint max_val(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p - 1;
  endfunction

  function automatic logic [55:0] render(input longint v, input bit blank, input int d);
    logic [55:0] r;
    longint p;
    r = '0;
    p = 1;
    for (int i = 0; i < d; i++) begin
      if (v > max_val(d))            r[7*i +: 7] = 7'h3F;
      else if (blank && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
      else                           r[7*i +: 7] = seg_tab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  bit          m_busy = 0;
  bit          m_valid = 0;
  int          m_rem = 0;
  longint      m_cur = 0;
  bit          m_pv = 0;
  longint      m_pend = 0;
  logic [55:0] m_hex5 = '1;
  logic [55:0] m_hex4 = '1;
  bit          m_ovf5 = 0;
  bit          m_ovf4 = 0;

  always @(posedge clk) begin
    m_valid = 0;
    if (reset) begin
      m_busy = 0; m_rem = 0; m_pv = 0;
      m_hex5 = '1; m_hex4 = '1; m_ovf5 = 0; m_ovf4 = 0;
    end else if (!m_busy) begin
      if (load) begin
        m_busy = 1; m_cur = longint'(binary); m_rem = BW + 1;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_hex5 = render(m_cur, blank_lz, 5);
        m_hex4 = render(m_cur, blank_lz, 4);
        m_ovf5 = m_cur > max_val(5);
        m_ovf4 = m_cur > max_val(4);
        m_valid = 1;
        if (load) begin
          m_cur = longint'(binary); m_rem = BW + 1; m_pv = 0;
        end else if (m_pv) begin
          m_cur = m_pend; m_rem = BW + 1; m_pv = 0;
        end else begin
          m_busy = 0;
        end
      end else if (load) begin
        m_pend = longint'(binary); m_pv = 1;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      check("hex5", 64'(hex5), 64'(m_hex5[34:0]));
      check("busy5", 64'(busy5), 64'(m_busy));
      check("valid5", 64'(valid5), 64'(m_valid));
      check("ovf5", 64'(ovf5), 64'(m_ovf5));
      check("hex4", 64'(hex4), 64'(m_hex4[27:0]));
      check("busy4", 64'(busy4), 64'(m_busy));
      check("valid4", 64'(valid4), 64'(m_valid));
      check("ovf4", 64'(ovf4), 64'(m_ovf4));
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [BW-1:0] v);
    binary = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid5 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (valid5 !== 1'b1) begin
      failures++;
      $display("FAIL valid_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  initial begin
    int n;
    logic [34:0] lit5;
    logic [27:0] lit4;

    @(negedge clk);
    @(negedge clk);
    check("rst_hex5", 64'(hex5), 64'({35{1'b1}}));
    check("rst_hex4", 64'(hex4), 64'({28{1'b1}}));
    check("rst_busy", 64'(busy5), 64'd0);
    check("rst_valid", 64'(valid5), 64'd0);
    check("rst_ovf", 64'(ovf5), 64'd0);
    reset = 1'b0;
    check_en = 1'b1;
    cyc(2);

    // 12345, no blanking
    blank_lz = 1'b0;
    do_load(16'd12345);
    wait_valid(n);
    check("lat_12345", 64'(n), 64'd17);
    lit5 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    check("lit_12345", 64'(hex5), 64'(lit5));
    cyc(2);

    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'd7);
    wait_valid(n);
    lit5 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
    check("lit_7_blank", 64'(hex5), 64'(lit5));
    cyc(1);
    do_load(16'd0);
    wait_valid(n);
    lit5 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    check("lit_0_blank", 64'(hex5), 64'(lit5));
    blank_lz = 1'b0;
    cyc(1);

    // 4-digit overflow boundary
    do_load(16'd10000);
    wait_valid(n);
    lit4 = {4{7'h3F}};
    check("lit_10000_d4", 64'(hex4), 64'(lit4));
    check("ovf_10000_d4", 64'(ovf4), 64'd1);
    cyc(1);
    do_load(16'd9999);
    wait_valid(n);
    lit4 = {4{7'h10}};
    check("lit_9999_d4", 64'(hex4), 64'(lit4));
    check("ovf_9999_d4", 64'(ovf4), 64'd0);
    cyc(1);

    // pending slot, last value wins
    do_load(16'd100);
    cyc(3);
    do_load(16'd200);
    cyc(2);
    do_load(16'd300);
    wait_valid(n);
    lit5 = {7'h40, 7'h40, 7'h79, 7'h40, 7'h40};
    check("lit_100", 64'(hex5), 64'(lit5));
    @(negedge clk);
    wait_valid(n);
    check("b2b_period", 64'(n + 1), 64'd17);
    lit5 = {7'h40, 7'h40, 7'h30, 7'h40, 7'h40};
    check("lit_300", 64'(hex5), 64'(lit5));
    cyc(2);

    // reset mid-conversion
    do_load(16'd12345);
    cyc(8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(busy5), 64'd0);
    check("midrst_hex", 64'(hex5), 64'({35{1'b1}}));
    cyc(20);
    do_load(16'd54321);
    wait_valid(n);
    check("lat_54321", 64'(n), 64'd17);
    lit5 = {7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    check("lit_54321", 64'(hex5), 64'(lit5));

    // randomized stimulus against the model
    for (int i = 0; i < 2500; i++) begin
      load = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0: binary = BW'($urandom_range(0, 20));
        1: binary = BW'($urandom_range(9990, 10010));
        2: binary = BW'($urandom_range(0, 65535));
        default: binary = BW'($urandom_range(0, 999));
      endcase
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    reset = 1'b0;
    cyc(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/number_display_seq.md
# number_display_seq

Parametrised sequential binary-to-seven-segment driver for the HEX0–HEX7 displays, succeeding the combinational per-display number decoders. It accepts an unsigned binary value from a Nios II PIO (e.g. game scores), converts it with an iterative shift-add-3 (double-dabble) engine over BIN_WIDTH cycles, and drives DIGITS active-low digit outputs from a registered display buffer. It adds leading-zero blanking, overflow indication and a one-deep pending-load buffer.

## Interface
- BIN_WIDTH, 16: width of the binary input; 1..32.
- DIGITS, 5: number of decimal digits driven; 1..8.
- BLINK_DIV, 25000000: half-period of blink, in clk cycles; used only with NUMBER_DISPLAY_BLINK_EN.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- binary  in  BIN_WIDTH  unsigned value to display.
- load  in  1  single-cycle request to convert `binary`.
- blank_lz  in  1  blank leading zeros; sampled in UPDATE.
- blink  in  1  blink enable; present only with NUMBER_DISPLAY_BLINK_EN.
- hex  out  7*DIGITS  segments, active-low; digit i at hex[7i+6:7i], bit 0 = a … bit 6 = g; digit 0 is the least significant.
- busy  out  1  conversion in progress (state ≠ IDLE).
- valid  out  1  one-cycle pulse when hex has been updated.
- overflow  out  1  last displayed value exceeded 10^DIGITS−1.

## Operation
- States: IDLE, SHIFT, UPDATE.
- IDLE
  - load=1: capture binary into the shift register; clear the BCD register (4*DIGITS bits) and the bit counter.
  - Record ovf_pend = (binary > 10^DIGITS−1), compared at full width.
  - Go to SHIFT.
- SHIFT, once per cycle:
  - Add 3 to every BCD nibble ≥5.
  - Shift {BCD, shift reg} left by one.
  - Increment the counter.
  - After the BIN_WIDTH-th shift, go to UPDATE.
- UPDATE:
  - Decode each nibble to segments: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex, active-low).
  - If blank_lz=1, digits above the highest nonzero digit are forced to 7F; digit 0 is never blanked.
  - If ovf_pend, every digit becomes 3F (dash, segment g only) and overflow=1; otherwise overflow=0.
  - Register hex and pulse valid.
  - If a pending load exists, reload it as in IDLE and go to SHIFT; otherwise go to IDLE.
- Pending buffer:
  - load while busy stores binary into a one-entry pending slot.
  - A later load before consumption overwrites it (last value wins); earlier pending values are dropped silently.
  - load in the same cycle as UPDATE is stored as pending.
- hex holds its value between updates; no output changes during SHIFT.
- Reset values:
  - State IDLE.
  - hex all 1s (all digits 7F, blank).
  - busy=0, valid=0, overflow=0.
  - Pending slot empty; BCD register, shift register and counter cleared.
- Reset mid-conversion aborts: no valid, and the pending value is discarded.

## Timing
- load sampled high at edge k (from IDLE):
  - busy=1 after edge k.
  - Shifts occur at edges k+1..k+BIN_WIDTH.
  - hex, overflow and valid=1 after edge k+BIN_WIDTH+1.
  - Latency is BIN_WIDTH+1 cycles (17 at defaults).
- valid is high for exactly one cycle.
- busy falls after the UPDATE edge when nothing is pending.
- With a pending load, SHIFT resumes immediately: back-to-back conversion period is BIN_WIDTH+1 cycles, with no IDLE gap.
- Throughput: one conversion per BIN_WIDTH+1 cycles maximum.

## Configuration
- NUMBER_DISPLAY_BLINK_EN defined:
  - Adds the blink port and a BLINK_DIV counter with a phase bit; on reset the counter is 0 and the phase is on.
  - The phase toggles every BLINK_DIV cycles.
  - While blink=1 and the phase is off, hex outputs all 7F. The displayed buffer is unaffected.
  - blink=0 forces the phase output on, while the counter keeps running.
- Not defined:
  - No blink port, no counter logic; BLINK_DIV is unused.
  - hex is driven directly from the display buffer.

## Test plan
- Reset for 2 cycles → hex all 7F, busy=0, valid=0, overflow=0.
- Defaults; load 12345, blank_lz=0 → valid exactly 17 cycles after load; digits 4..0 = 79,24,30,19,12; busy high for 17 cycles.
- load 7 with blank_lz=1 → digit 0 = 78, digits 1–4 = 7F; then load 0 → digit 0 = 40, others 7F.
- DIGITS=4; load 10000 → overflow=1, all digits 3F; then load 9999 → overflow=0, all digits 10.
- load 100, then load 200 and load 300 during busy → two valid pulses 17 cycles apart showing 100 then 300; 200 is never displayed.
- Reset asserted at shift 8 of a conversion → busy=0 next cycle, hex all 7F, no valid pulse; a subsequent load converts normally.
